// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port register file with registered reads,
//               byte-masked writes, optional write-to-read bypass, hardwired
//               zero register and a per-register pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_RD-1:0]            RD_EN,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
    output logic [NUM_RD-1:0]            RD_VALID,
    output logic [NUM_RD-1:0]            RD_PEND,
    input  logic                         WR_EN,
    input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
    input  logic [DATA_WIDTH-1:0]        WR_DATA,
    input  logic [DATA_WIDTH/8-1:0]      WR_BE,
    input  logic                         RSV_EN,
    input  logic [ADDR_WIDTH-1:0]        RSV_ADDR
);

    localparam int c_DEPTH  = 1 << ADDR_WIDTH;
    localparam int c_NBYTES = DATA_WIDTH / 8;

    // Storage and scoreboard
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]    r_pend;

    // Registered read outputs
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] r_rd_data;
    logic [NUM_RD-1:0]                 r_rd_valid;
    logic [NUM_RD-1:0]                 r_rd_pend;

    // Per-port combinational read results
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] w_rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]                 w_rd_pend;

    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    // Register 0 is immune to writes and reservations when hardwired to zero
    assign w_wr_ok  = WR_EN  && !((ZERO_REG != 0) && (WR_ADDR  == '0));
    assign w_rsv_ok = RSV_EN && !((ZERO_REG != 0) && (RSV_ADDR == '0));

    // Unpack the flat read-address bus into one field per port
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
            assign w_rd_addr[k] = RD_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Byte-merge the incoming write data over the current register contents
    always_comb begin
        w_wr_merged = r_mem[WR_ADDR];
        for (int b = 0; b < c_NBYTES; b++) begin
            if (WR_BE[b]) begin
                w_wr_merged[b*8 +: 8] = WR_DATA[b*8 +: 8];
            end
        end
    end

    // Read-side lookup: forward a same-cycle write when bypass is enabled,
    // and force register 0 to read zero / not pending when hardwired
    always_comb begin
        w_rd_data = '0;
        w_rd_pend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((BYPASS != 0) && w_wr_ok && (WR_ADDR == w_rd_addr[k])) begin
                w_rd_data[k] = w_wr_merged;
                w_rd_pend[k] = 1'b0;
            end else begin
                w_rd_data[k] = r_mem[w_rd_addr[k]];
                w_rd_pend[k] = r_pend[w_rd_addr[k]];
            end
            if ((ZERO_REG != 0) && (w_rd_addr[k] == '0)) begin
                w_rd_data[k] = '0;
                w_rd_pend[k] = 1'b0;
            end
        end
    end

    // State update: writes, pending scoreboard (reserve overrides the
    // write's clear by being the later assignment) and registered reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_rd_pend  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[WR_ADDR]  <= w_wr_merged;
                r_pend[WR_ADDR] <= 1'b0;
            end
            if (w_rsv_ok) begin
                r_pend[RSV_ADDR] <= 1'b1;
            end
            r_rd_valid <= RD_EN;
            for (int k = 0; k < NUM_RD; k++) begin
                if (RD_EN[k]) begin
                    r_rd_data[k] <= w_rd_data[k];
                    r_rd_pend[k] <= w_rd_pend[k];
                end
            end
        end
    end

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign RD_PEND  = r_rd_pend;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp. Two instances
//               share stimulus: u_dut (BYPASS=1, ZERO_REG=1) and u_dut_nb
//               (BYPASS=0, ZERO_REG=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_valid, rd_valid_nb;
    logic [1:0]  rd_pend, rd_pend_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int n_total = 0;
    int n_bad   = 0;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .CLK(clk), .RST(rst), .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .RD_VALID(rd_valid), .RD_PEND(rd_pend), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .WR_BE(wr_be), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr)
    );

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_dut_nb (
        .CLK(clk), .RST(rst), .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data_nb),
        .RD_VALID(rd_valid_nb), .RD_PEND(rd_pend_nb), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .WR_BE(wr_be), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = 2'b00; wr_en = 1'b0; rsv_en = 1'b0; wr_be = 4'h0;
    endtask

    task automatic do_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle();
    endtask

    task automatic do_rd(input logic [4:0] a0, input logic [4:0] a1);
        idle();
        rd_en = 2'b11; rd_addr = {a1, a0};
        tick();
        idle();
    endtask

    initial begin
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        rst = 1'b1;
        tick();
        chk("reset_valid", {62'd0, rd_valid}, 64'd0);
        chk("reset_data", rd_data, 64'd0);

        // 1: populate, reserve, then reset while read/write/reserve are active
        do_wr(5'd1, 32'h1234_5678, 4'hF);
        do_wr(5'd2, 32'hCAFE_F00D, 4'hF);
        do_wr(5'd31, 32'h5A5A_A5A5, 4'hF);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd2; tick();
        do_rd(5'd1, 5'd31);
        chk("pre_rst_data", rd_data, {32'h5A5A_A5A5, 32'h1234_5678});
        idle();
        rst = 1'b1; rd_en = 2'b11; rd_addr = {5'd2, 5'd1};
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        chk("rst_valid", {62'd0, rd_valid}, 64'd0);
        chk("rst_data", rd_data, 64'd0);
        chk("rst_pend", {62'd0, rd_pend}, 64'd0);
        for (int a = 1; a < 32; a++) begin
            do_rd(a[4:0], a[4:0]);
            chk($sformatf("rst_clear_%0d", a), {rd_pend, rd_data}, 66'd0);
        end

        // 2: write i*2 to 1..9, read i / 10-i on the two ports
        for (int i = 1; i <= 9; i++) do_wr(i[4:0], 32'(i * 2), 4'hF);
        for (int i = 1; i <= 9; i++) begin
            do_rd(i[4:0], 5'(10 - i));
            chk($sformatf("rd_p0_%0d", i), rd_data[31:0], 64'(i * 2));
            chk($sformatf("rd_p1_%0d", i), rd_data[63:32], 64'((10 - i) * 2));
            chk($sformatf("rd_valid_%0d", i), {62'd0, rd_valid}, 64'd3);
        end
        idle(); tick();
        chk("valid_drop", {62'd0, rd_valid}, 64'd0);
        chk("data_hold", rd_data, {32'd2, 32'd18});

        // 3: byte-masked write
        do_wr(5'd3, 32'h1122_3344, 4'hF);
        do_wr(5'd3, 32'hAABB_CCDD, 4'b0101);
        do_rd(5'd3, 5'd3);
        chk("be_merge", rd_data[31:0], 64'h11BB_33DD);
        chk("be_merge_nb", rd_data_nb[63:32], 64'h11BB_33DD);

        // 4: same-cycle write+read, full then partial bytes
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        tick();
        chk("bypass_both", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        chk("nobypass_old", rd_data_nb[31:0], 64'd10);
        do_rd(5'd5, 5'd5);
        chk("nobypass_new", rd_data_nb[31:0], 64'hDEAD_BEEF);
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; wr_be = 4'b0011;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        tick();
        chk("bypass_partial", rd_data[31:0], 64'hDEAD_5678);
        chk("nobypass_partial", rd_data_nb[31:0], 64'hDEAD_BEEF);

        // 5: pending scoreboard
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; tick();
        do_rd(5'd7, 5'd1);
        chk("pend_set", {62'd0, rd_pend}, 64'd1);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd8; rd_en = 2'b01; rd_addr = {5'd0, 5'd8}; tick();
        chk("pend_rsv_same_cycle", {63'd0, rd_pend[0]}, 64'd0);
        do_rd(5'd8, 5'd8);
        chk("pend_rsv_after", {62'd0, rd_pend}, 64'd3);
        do_wr(5'd7, 32'hFFFF_FFFF, 4'h0);
        do_rd(5'd7, 5'd7);
        chk("pend_clr_be0", {62'd0, rd_pend}, 64'd0);
        chk("be0_noop", rd_data[31:0], 64'd14);
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; wr_be = 4'hF;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        do_rd(5'd7, 5'd7);
        chk("wr_rsv_pend", {62'd0, rd_pend}, 64'd3);
        chk("wr_rsv_data", rd_data[31:0], 64'h77);
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99; wr_be = 4'hF;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        tick();
        chk("bypass_pend", {rd_pend[0], rd_data[31:0]}, {31'd0, 1'b0, 32'h99});
        chk("nobypass_pend", {rd_pend_nb[0], rd_data_nb[31:0]}, {31'd0, 1'b1, 32'h77});

        // 6: register 0 write + reserve
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        do_rd(5'd0, 5'd0);
        chk("zero_data", rd_data, 64'd0);
        chk("zero_pend", {62'd0, rd_pend}, 64'd0);
        chk("nonzero_data", rd_data_nb, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        chk("nonzero_pend", {62'd0, rd_pend_nb}, 64'd3);
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1357_9BDF; wr_be = 4'hF;
        rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
        tick();
        chk("zero_bypass", rd_data[63:32], 64'd0);

        // Mid-stream reset discards in-flight read
        idle(); rd_en = 2'b11; rd_addr = {5'd9, 5'd3}; tick();
        chk("pre_midrst", {62'd0, rd_valid}, 64'd3);
        idle(); rst = 1'b1; rd_en = 2'b11; tick();
        chk("midrst", {rd_valid, rd_data}, 66'd0);
        idle(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
